ps2_frontend: RTL and testbench



---
 rtl/ps2_frontend.sv | 159 +++++++++++++++
 tb/tb_ps2_frontend.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frontend.sv
// PS/2 pin conditioning: two-flop synchronisers, per-line glitch filters, falling-edge
// strobe with sampled data bit, and an 11-bit frame tracker with in-frame timeout.
module ps2_frontend #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_f,
  output logic       ps2_data_f,
  output logic       fall_stb,
  output logic       fall_bit,
  output logic [3:0] bit_idx,
  output logic       busy,
  output logic       frame_end,
  output logic       stop_err,
  output logic       frame_abort
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FCW-1:0] F_TERM   = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] T_TERM   = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     STOP_IDX = 4'd10;

  typedef enum logic {IDLE, RX} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic [1:0]             sync_s;
  logic [1:0]             filt_q, filt_d;
  logic [FCW-1:0]         fcnt_q [2];
  logic [FCW-1:0]         fcnt_d [2];
  logic                   clk_f_prev_q;
  logic                   fall_bit_q;
  state_e                 state_q, state_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [TCW-1:0]         tmo_q, tmo_d;
  logic                   frame_end_q, frame_end_d;
  logic                   stop_err_q, stop_err_d;
  logic                   frame_abort_q, frame_abort_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign sync_s = {data_sync_q[SYNC_STAGES-1], clk_sync_q[SYNC_STAGES-1]};

  // Index 0 is the clock line, index 1 the data line; both filters are identical.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a value unassigned (no latches).
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      if (sync_s[i] != filt_q[i]) begin
        if (fcnt_q[i] == F_TERM) begin
          filt_d[i] = sync_s[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q       <= 2'b11;
      fcnt_q[0]    <= '0;
      fcnt_q[1]    <= '0;
      clk_f_prev_q <= 1'b1;
      fall_bit_q   <= 1'b1;
    end else begin
      filt_q       <= filt_d;
      fcnt_q[0]    <= fcnt_d[0];
      fcnt_q[1]    <= fcnt_d[1];
      clk_f_prev_q <= filt_q[0];
      if (fall_stb) fall_bit_q <= filt_q[1];
    end
  end

  assign fall_stb = clk_f_prev_q & ~filt_q[0];

  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    tmo_d         = tmo_q;
    frame_end_d   = 1'b0;
    stop_err_d    = 1'b0;
    frame_abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (fall_stb && !filt_q[1]) begin
          state_d   = RX;
          bit_idx_d = 4'd1;
        end
      end
      RX: begin
        if (fall_stb) begin
          tmo_d = '0;
          if (bit_idx_q == STOP_IDX) begin
            frame_end_d = 1'b1;
            stop_err_d  = ~filt_q[1];
            state_d     = IDLE;
            bit_idx_d   = 4'd0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else if (tmo_q == T_TERM) begin
          // A strobe in the terminal-count cycle takes the branch above, so it always wins.
          frame_abort_d = 1'b1;
          state_d       = IDLE;
          bit_idx_d     = 4'd0;
          tmo_d         = '0;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_idx_q     <= 4'd0;
      tmo_q         <= '0;
      frame_end_q   <= 1'b0;
      stop_err_q    <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      tmo_q         <= tmo_d;
      frame_end_q   <= frame_end_d;
      stop_err_q    <= stop_err_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign ps2_clk_f   = filt_q[0];
  assign ps2_data_f  = filt_q[1];
  assign fall_bit    = fall_bit_q;
  assign bit_idx     = bit_idx_q;
  assign busy        = (state_q == RX);
  assign frame_end   = frame_end_q;
  assign stop_err    = stop_err_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_ps2_frontend.sv
// Bench for ps2_frontend: randomized PS/2 frames, glitches and timeouts checked against a
// frame-level model (pin events plus fixed conditioning latency, frame bits from the byte).
module tb_ps2_frontend;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  always #5 clk = ~clk;

  logic clk_f, data_f, fall_stb, fall_bit, busy, frame_end, stop_err, frame_abort;
  logic [3:0] bit_idx;
  logic t_clk_f, t_data_f, t_fall_stb, t_fall_bit, t_busy, t_frame_end, t_stop_err, t_frame_abort;
  logic [3:0] t_bit_idx;

  ps2_frontend dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_clk_f(clk_f), .ps2_data_f(data_f), .fall_stb(fall_stb), .fall_bit(fall_bit),
    .bit_idx(bit_idx), .busy(busy), .frame_end(frame_end), .stop_err(stop_err),
    .frame_abort(frame_abort)
  );

  ps2_frontend #(.TIMEOUT_CYCLES(100)) dut_t (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_clk_f(t_clk_f), .ps2_data_f(t_data_f), .fall_stb(t_fall_stb), .fall_bit(t_fall_bit),
    .bit_idx(t_bit_idx), .busy(t_busy), .frame_end(t_frame_end), .stop_err(t_stop_err),
    .frame_abort(t_frame_abort)
  );

  // Pin edge to filtered edge: SYNC_STAGES + FILTER_LEN with defaults.
  localparam int LAT = 10;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log (DUT outputs only); expectations come from the tasks below.
  int   stb_cyc_q[$];
  logic fb_q[$];
  int   idx_q[$];
  logic busy_q[$];
  int   fe_q[$];
  logic se_q[$];
  int   ab_q[$];
  int   t_fe_q[$];
  logic t_se_q[$];
  int   t_ab_q[$];
  int   clk_f_low = 0;
  int   data_f_low = 0;
  int   viol = 0;
  logic stb_d = 1'b0;

  always @(negedge clk) begin
    if (stb_d) begin
      fb_q.push_back(fall_bit);
      idx_q.push_back(int'(bit_idx));
      busy_q.push_back(busy);
    end
    stb_d = fall_stb;
    if (fall_stb) stb_cyc_q.push_back(cyc);
    if (frame_end) begin fe_q.push_back(cyc); se_q.push_back(stop_err); end
    if (frame_abort) ab_q.push_back(cyc);
    if (t_frame_end) begin t_fe_q.push_back(cyc); t_se_q.push_back(t_stop_err); end
    if (t_frame_abort) t_ab_q.push_back(cyc);
    if (!clk_f) clk_f_low++;
    if (!data_f) data_f_low++;
    if ((frame_end && frame_abort) || (t_frame_end && t_frame_abort)) viol++;
    if ((stop_err && !frame_end) || (t_stop_err && !t_frame_end)) viol++;
  end

  int exp_pin_q[$];

  function automatic logic [10:0] make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic send_bit(input logic b, input int half);
    @(posedge clk); #1 ps2_data = b;
    repeat (half) @(posedge clk);
    #1 ps2_clk = 1'b0;
    exp_pin_q.push_back(cyc);
    repeat (half) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    do_reset();
    @(negedge clk);
    obs = {clk_f, data_f, fall_stb, fall_bit, bit_idx, busy, frame_end, stop_err, frame_abort};
    checks++;
    if (obs !== 12'b1101_0000_0000) begin
      errors++; $display("FAIL reset_values: got %b expected 110100000000", obs);
    end
  endtask

  task automatic test_idle();
    int b_stb = stb_cyc_q.size();
    int b_low = clk_f_low;
    int b_dlow = data_f_low;
    repeat (200) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stb_cyc_q.size() !== b_stb) begin
      errors++; $display("FAIL idle_no_stb: got %0d strobes expected 0", stb_cyc_q.size() - b_stb);
    end
    checks++;
    if ((clk_f_low - b_low) + (data_f_low - b_dlow) !== 0 || busy !== 1'b0 || bit_idx !== 4'd0) begin
      errors++; $display("FAIL idle_state: clk_f_low=%0d data_f_low=%0d busy=%b idx=%0d expected 0 0 0 0",
                         clk_f_low - b_low, data_f_low - b_dlow, busy, bit_idx);
    end
  endtask

  // Clock pin held low from cycle T: strobe exactly in T+LAT; rising edge adds none.
  // Data is high, so this is also a spurious IDLE edge that must leave busy and bit_idx at 0.
  task automatic test_edge_latency();
    int t;
    int b_stb = stb_cyc_q.size();
    @(posedge clk); #1 ps2_clk = 1'b0; t = cyc;
    repeat (30) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stb_cyc_q.size() - b_stb !== 1) begin
      errors++; $display("FAIL fall_count: got %0d expected 1", stb_cyc_q.size() - b_stb);
    end else begin
      checks++;
      if (stb_cyc_q[b_stb] !== t + LAT) begin
        errors++; $display("FAIL fall_latency: got cycle %0d expected %0d", stb_cyc_q[b_stb], t + LAT);
      end
    end
    checks++;
    if (clk_f !== 1'b0 || busy !== 1'b0 || bit_idx !== 4'd0 || fall_bit !== 1'b1) begin
      errors++; $display("FAIL spurious_edge: clk_f=%b busy=%b idx=%0d fall_bit=%b expected 0 0 0 1",
                         clk_f, busy, bit_idx, fall_bit);
    end
    @(posedge clk); #1 ps2_clk = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stb_cyc_q.size() - b_stb !== 1 || clk_f !== 1'b1) begin
      errors++; $display("FAIL rise_no_stb: strobes=%0d clk_f=%b expected 1 1", stb_cyc_q.size() - b_stb, clk_f);
    end
  endtask

  task automatic pulse_pin(input bit on_clk, input int len);
    @(posedge clk); #1;
    if (on_clk) ps2_clk = 1'b0; else ps2_data = 1'b0;
    repeat (len) @(posedge clk);
    #1;
    if (on_clk) ps2_clk = 1'b1; else ps2_data = 1'b1;
    repeat (30) @(posedge clk);
  endtask

  task automatic test_glitch();
    int b_stb = stb_cyc_q.size();
    int b_low = clk_f_low;
    int b_dlow = data_f_low;
    int g = $urandom_range(1, 7);
    pulse_pin(1'b1, 7);
    pulse_pin(1'b1, g);
    pulse_pin(1'b0, $urandom_range(1, 7));
    @(negedge clk);
    checks++;
    if (stb_cyc_q.size() !== b_stb || clk_f_low !== b_low || data_f_low !== b_dlow) begin
      errors++; $display("FAIL glitch_filtered: strobes=%0d clk_low=%0d data_low=%0d expected 0 0 0",
                         stb_cyc_q.size() - b_stb, clk_f_low - b_low, data_f_low - b_dlow);
    end
    // Exactly FILTER_LEN cycles low passes and shows up as an 8-cycle low on the filtered line.
    pulse_pin(1'b0, 8);
    @(negedge clk);
    checks++;
    if (data_f_low - b_dlow !== 8 || busy !== 1'b0) begin
      errors++; $display("FAIL min_pulse_pass: got %0d low cycles busy=%b expected 8 0", data_f_low - b_dlow, busy);
    end
  endtask

  task automatic run_frame(input logic [10:0] bits, input int half, input string name,
                           input bit chk_main, input bit chk_t);
    int b_stb = stb_cyc_q.size();
    int b_fb  = fb_q.size();
    int b_fe  = fe_q.size();
    int b_ab  = ab_q.size();
    int b_tfe = t_fe_q.size();
    int b_tab = t_ab_q.size();
    int b_pin = exp_pin_q.size();
    int end_exp;
    for (int i = 0; i < 11; i++) send_bit(bits[i], half);
    repeat (40) @(posedge clk);
    @(negedge clk);
    end_exp = exp_pin_q[b_pin+10] + LAT + 1;
    if (chk_main) begin
      checks++;
      if (stb_cyc_q.size() - b_stb !== 11) begin
        errors++; $display("FAIL %s_stb_count: got %0d expected 11", name, stb_cyc_q.size() - b_stb);
      end else begin
        for (int i = 0; i < 11; i++) begin
          checks++;
          if (stb_cyc_q[b_stb+i] !== exp_pin_q[b_pin+i] + LAT || fb_q[b_fb+i] !== bits[i] ||
              idx_q[b_fb+i] !== (i + 1) % 11 || busy_q[b_fb+i] !== (i < 10)) begin
            errors++;
            $display("FAIL %s_edge%0d: cyc=%0d bit=%b idx=%0d busy=%b expected %0d %b %0d %b", name, i,
                     stb_cyc_q[b_stb+i], fb_q[b_fb+i], idx_q[b_fb+i], busy_q[b_fb+i],
                     exp_pin_q[b_pin+i] + LAT, bits[i], (i + 1) % 11, i < 10);
          end
        end
      end
      checks++;
      if (fe_q.size() - b_fe !== 1 || ab_q.size() !== b_ab) begin
        errors++; $display("FAIL %s_frame_end_count: got %0d ends %0d aborts expected 1 0", name,
                           fe_q.size() - b_fe, ab_q.size() - b_ab);
      end else begin
        checks++;
        if (fe_q[b_fe] !== end_exp || se_q[b_fe] !== ~bits[10]) begin
          errors++; $display("FAIL %s_frame_end: cyc=%0d stop_err=%b expected %0d %b", name,
                             fe_q[b_fe], se_q[b_fe], end_exp, ~bits[10]);
        end
      end
      checks++;
      if (busy !== 1'b0 || bit_idx !== 4'd0) begin
        errors++; $display("FAIL %s_after: busy=%b idx=%0d expected 0 0", name, busy, bit_idx);
      end
    end
    if (chk_t) begin
      checks++;
      if (t_fe_q.size() - b_tfe !== 1 || t_ab_q.size() !== b_tab || t_busy !== 1'b0) begin
        errors++; $display("FAIL %s_t_frame: ends=%0d aborts=%0d busy=%b expected 1 0 0", name,
                           t_fe_q.size() - b_tfe, t_ab_q.size() - b_tab, t_busy);
      end else begin
        checks++;
        if (t_fe_q[b_tfe] !== end_exp || t_se_q[b_tfe] !== ~bits[10]) begin
          errors++; $display("FAIL %s_t_frame_end: cyc=%0d stop_err=%b expected %0d %b", name,
                             t_fe_q[b_tfe], t_se_q[b_tfe], end_exp, ~bits[10]);
        end
      end
    end
  endtask

  task automatic test_frame_1c();
    do_reset();
    run_frame(make_frame(8'h1C), 1000, "frame_1c", 1'b1, 1'b0);
  endtask

  task automatic test_stop_err();
    logic [10:0] f = make_frame(8'($urandom));
    f[10] = 1'b0;
    do_reset();
    run_frame(f, 100, "stop_err", 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 3; k++)
      run_frame(make_frame(8'($urandom)), $urandom_range(15, 40), "rand_frame", 1'b1, 1'b1);
  endtask

  // Last strobe in cycle S clears the counter; it reads 99 in S+100, so the abort pulse is in S+101.
  task automatic test_timeout();
    int b_tab, b_tfe, s;
    do_reset();
    b_tab = t_ab_q.size();
    b_tfe = t_fe_q.size();
    send_bit(1'b0, 20);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), 20);
    s = exp_pin_q[exp_pin_q.size()-1] + LAT;
    repeat (250) @(posedge clk);
    @(negedge clk);
    checks++;
    if (t_ab_q.size() - b_tab !== 1 || t_fe_q.size() !== b_tfe) begin
      errors++; $display("FAIL timeout_count: aborts=%0d ends=%0d expected 1 0",
                         t_ab_q.size() - b_tab, t_fe_q.size() - b_tfe);
    end else begin
      checks++;
      if (t_ab_q[b_tab] !== s + 101) begin
        errors++; $display("FAIL timeout_cycle: got %0d expected %0d", t_ab_q[b_tab], s + 101);
      end
    end
    checks++;
    if (t_busy !== 1'b0 || t_bit_idx !== 4'd0) begin
      errors++; $display("FAIL timeout_state: busy=%b idx=%0d expected 0 0", t_busy, t_bit_idx);
    end
    run_frame(make_frame(8'($urandom)), 20, "after_abort", 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] obs;
    int b_fe, b_ab, b_tfe, b_tab;
    do_reset();
    send_bit(1'b0, 20);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 20);
    @(negedge clk);
    checks++;
    if (bit_idx !== 4'd5 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_frame_pos: idx=%0d busy=%b expected 5 1", bit_idx, busy);
    end
    b_fe = fe_q.size(); b_ab = ab_q.size(); b_tfe = t_fe_q.size(); b_tab = t_ab_q.size();
    @(posedge clk); #1 rst = 1'b1; ps2_data = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    obs = {clk_f, data_f, fall_stb, fall_bit, bit_idx, busy, frame_end, stop_err, frame_abort};
    checks++;
    if (obs !== 12'b1101_0000_0000 || t_busy !== 1'b0 || t_bit_idx !== 4'd0) begin
      errors++; $display("FAIL mid_reset_values: got %b t_busy=%b t_idx=%0d expected 110100000000 0 0",
                         obs, t_busy, t_bit_idx);
    end
    repeat (300) @(posedge clk);
    @(negedge clk);
    checks++;
    if (fe_q.size() !== b_fe || ab_q.size() !== b_ab || t_fe_q.size() !== b_tfe || t_ab_q.size() !== b_tab) begin
      errors++; $display("FAIL mid_reset_discard: ends=%0d aborts=%0d t_ends=%0d t_aborts=%0d expected 0 0 0 0",
                         fe_q.size() - b_fe, ab_q.size() - b_ab, t_fe_q.size() - b_tfe, t_ab_q.size() - b_tab);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_edge_latency();
    test_glitch();
    test_frame_1c();
    test_stop_err();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL pulse_exclusivity: got %0d bad cycles expected 0", viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
